// File: rtl/bool_unit_iter_if.sv
// Handshake/operand bundle for bool_unit_iter.
//   master: flush, in_valid, ALUOp, A, B, out_ready  ->  unit
//   slave : in_ready, out_valid, boolout, zero, illegal, busy  ->  consumer
interface bool_unit_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] boolout;
  logic             zero;
  logic             illegal;
  logic             busy;

  modport master (
    output flush, in_valid, ALUOp, A, B, out_ready,
    input  in_ready, out_valid, boolout, zero, illegal, busy
  );

  modport slave (
    input  flush, in_valid, ALUOp, A, B, out_ready,
    output in_ready, out_valid, boolout, zero, illegal, busy
  );
endinterface

// File: rtl/bool_unit_iter.sv
// Iterative 2-input boolean unit: boolout[i] = ALUOp[{B[i],A[i]}], evaluated
// SLICE bits per cycle (LSB slice first) after a valid/ready accept.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - bool_unit_iter_if.slave: flush, in_valid/in_ready, ALUOp, A, B,
//           out_valid/out_ready, boolout, zero, illegal, busy
// Parameters: WIDTH operand width, SLICE bits per cycle (divides WIDTH),
//   STRICT = 1 restricts ALUOp to the six legacy Beta encodings.
module bool_unit_iter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SLICE  = 8,
  parameter bit          STRICT = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  bool_unit_iter_if.slave bus
);
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if ((SLICE == 0) || (WIDTH % SLICE != 0)) begin : g_bad_slice
    $error("bool_unit_iter: SLICE must be nonzero and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] boolout_q;
  logic             zero_q, illegal_q;

  logic             legal;
  logic [SLICE-1:0] a_sl, b_sl, f_sl;
  logic [WIDTH-1:0] boolout_d;

  always_comb begin
    legal = !STRICT || (op_q inside {4'b1010, 4'b1000, 4'b0001,
                                     4'b1110, 4'b1001, 4'b0110});
  end

  // Only the current slice of the captured operands is evaluated; the
  // result is merged into the accumulated boolout at the same position.
  always_comb begin
    a_sl      = '0;
    b_sl      = '0;
    f_sl      = '0;
    boolout_d = boolout_q;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      if (cnt_q == CW'(s)) begin
        a_sl = a_q[s*SLICE +: SLICE];
        b_sl = b_q[s*SLICE +: SLICE];
      end
    end
    for (int unsigned j = 0; j < SLICE; j++) begin
      f_sl[j] = legal ? op_q[{b_sl[j], a_sl[j]}] : 1'b0;
    end
    for (int unsigned s = 0; s < NSLICE; s++) begin
      if (cnt_q == CW'(s)) begin
        boolout_d[s*SLICE +: SLICE] = f_sl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      boolout_q <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      boolout_q <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            a_q       <= bus.A;
            b_q       <= bus.B;
            op_q      <= bus.ALUOp;
            boolout_q <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
          end
        end
        RUN: begin
          boolout_q <= boolout_d;
          if (cnt_q == LAST) begin
            // Flags come from the fully assembled result on the final slice.
            state_q   <= DONE;
            cnt_q     <= '0;
            zero_q    <= (boolout_d == '0);
            illegal_q <= !legal;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.boolout   = boolout_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: doc/bool_unit_iter.md
Name: bool_unit_iter

Overview:
Parametrised, multi-cycle successor to the Beta ALU boolean unit. It evaluates any 2-input bitwise function, encoded as a 4-bit truth table on ALUOp, over WIDTH-bit operands. It processes SLICE bits per cycle behind valid/ready handshakes. It sits between the ALU operand registers and the ALU result mux, and also produces zero and illegal-op flags.

Parameters:
WIDTH, 32, operand/result width in bits.
SLICE, 8, bits evaluated per cycle; must divide WIDTH; NSLICE = WIDTH/SLICE.
STRICT, 1, 1 = only the six legacy Beta encodings are legal; 0 = all 16 truth tables are legal.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous abort; drops any operation in flight.
in_valid  input  1  operands/op presented.
in_ready  output  1  unit can accept a new operation.
ALUOp  input  4  truth-table function code.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
boolout  output  WIDTH  result.
zero  output  1  boolout == 0.
illegal  output  1  ALUOp was not legal under STRICT.
busy  output  1  state != IDLE.

Behaviour:
- Function: for each bit i, boolout[i] = ALUOp[{B[i],A[i]}], where index 0 means B=0,A=0 and index 3 means B=1,A=1.
- Legacy encodings: 1010 A, 1000 AND, 0001 NOR, 1110 OR, 1001 XNOR, 0110 XOR.
- STRICT=1:
  - Any other code produces boolout = 0 and illegal = 1.
  - Such a code still runs the full NSLICE cycles, so latency is uniform.
- STRICT=0: illegal is always 0.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - RUN: slice counter cnt runs 0..NSLICE-1.
  - DONE: out_valid = 1, in_ready = 0.
- IDLE -> RUN on in_valid && in_ready. On that edge, A, B and ALUOp are captured into internal registers, cnt is set to 0, and boolout, zero and illegal are cleared.
- RUN, each edge:
  - Writes boolout[cnt*SLICE +: SLICE] from the captured operands, LSB slice first.
  - Increments cnt.
  - When cnt == NSLICE-1, moves to DONE.
  - Port A/B/ALUOp changes during RUN have no effect.
- Latency: out_valid rises exactly NSLICE cycles after the accept edge. With SLICE = WIDTH this is 1 cycle.
- zero and illegal are valid whenever out_valid = 1. zero is computed from the complete result.
- DONE:
  - boolout, zero and illegal are held stable while out_ready = 0.
  - On out_ready = 1, the state returns to IDLE and boolout keeps its value.
  - No new operation is accepted in the same cycle; the next accept is possible one cycle later.
- Sampled in IDLE, out_ready is ignored. Sampled outside IDLE, in_valid is ignored.
- flush:
  - Any state -> IDLE on the next edge; cnt = 0; out_valid drops.
  - boolout, zero and illegal are cleared to 0.
  - flush has priority over both handshakes in the same cycle.
- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0.
  - boolout = 0, zero = 0, illegal = 0, out_valid = 0, busy = 0.
  - in_ready = 1 while in reset.
  - Reset mid-RUN or mid-DONE discards the operation. The first accept is possible on the first edge after release.
- Outputs out_valid, in_ready and busy decode directly from the state register; none are combinational from inputs.
- Widths: ALUOp is exactly 4 bits. cnt has width clog2(NSLICE), minimum 1.
- Elaboration error if WIDTH % SLICE != 0.

Test Plan:
- WIDTH=32, SLICE=8, AND (1000), A=0xF0F01234, B=0x0FF0FFFF, accept at cycle T -> out_valid first high at T+4; boolout = 0x00F01234, zero = 0, illegal = 0.
- XOR (0110), A = B = 0xDEADBEEF -> boolout = 0x00000000, zero = 1. Then XNOR, same operands -> boolout = 0xFFFFFFFF, zero = 0.
- STRICT=1, ALUOp = 0011, B = 0x0000FFFF -> boolout = 0, illegal = 1, latency 4. STRICT=0, same stimulus -> boolout = 0xFFFF0000 (~B), illegal = 0.
- Back-pressure: out_ready held low 5 cycles in DONE, in_valid held high with new operands -> boolout stable, in_ready = 0, no second accept. out_ready pulse -> IDLE, then the next operation is accepted one cycle later.
- Abort: flush at cnt = 2 of a 4-slice OR, then (separate run) rst_n low at cnt = 1 -> next edge/immediately: IDLE, out_valid = 0, boolout = 0. A fresh op completes with a correct result 4 cycles after its accept.
- SLICE=32 build, A (1010), A = 0x12345678 -> out_valid one cycle after accept, boolout = 0x12345678. Back-to-back ops with out_ready tied high sustain one result every 3 cycles.
